// File: rtl/bcd_convertor.sv
// Signed binary to packed BCD converter for the calculator display path.
// A double-dabble engine processes one magnitude bit per clock.
module bcd_convertor #(
  parameter int WIDTH       = 28,
  parameter int DIGITS      = 9,
  parameter int DISP_DIGITS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  input  logic [WIDTH-1:0]      d_in,
  input  logic                  err_in,
  output logic                  busy,
  output logic                  valid_out,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  sign,
  output logic                  err_out,
  output logic                  ovr_disp,
  output logic [1:0]            dbg_state_o
);

  // Handshake: valid_in is a one-cycle strobe taken only while busy=0 (IDLE);
  // valid_out is a one-cycle strobe; result outputs hold until the next one.

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] mag_q, mag_d;
  logic [BW-1:0]    bcd_q, bcd_d;
  logic             sign_q, sign_d;
  logic             err_pend_q, err_pend_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
  logic [BW-1:0]    bcd_out_q, bcd_out_d;
  logic             sign_out_q, sign_out_d;
  logic             err_out_q, err_out_d;
  logic             ovr_q, ovr_d;

  logic [WIDTH-1:0]    mag_in;
  logic [BW-1:0]       bcd_adj;
  logic [BW+WIDTH-1:0] shift_cat;
  logic                high_digits_nz;

  // Two's-complement negate in an unsigned WIDTH-bit field: the most negative
  // value maps to 2^(WIDTH-1) without wrapping.
  assign mag_in = d_in[WIDTH-1] ? (~d_in + {{(WIDTH-1){1'b0}}, 1'b1}) : d_in;

  always_comb begin
    bcd_adj = '0;
    for (int i = 0; i < DIGITS; i++) begin
      bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? (bcd_q[4*i +: 4] + 4'd3)
                                                    : bcd_q[4*i +: 4];
    end
  end

  assign shift_cat      = {bcd_adj, mag_q} << 1;
  assign high_digits_nz = |bcd_q[BW-1:4*DISP_DIGITS];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mag_d      = mag_q;
    bcd_d      = bcd_q;
    sign_d     = sign_q;
    err_pend_d = err_pend_q;
    busy_d     = busy_q;
    valid_d    = 1'b0;
    bcd_out_d  = bcd_out_q;
    sign_out_d = sign_out_q;
    err_out_d  = err_out_q;
    ovr_d      = ovr_q;

    case (state_q)
      IDLE: begin
        if (valid_in) begin
          busy_d = 1'b1;
          if (err_in) begin
            // Error results bypass conversion; outputs update immediately.
            err_pend_d = 1'b1;
            err_out_d  = 1'b1;
            bcd_out_d  = '0;
            sign_out_d = 1'b0;
            ovr_d      = 1'b0;
            state_d    = DONE;
          end else begin
            err_pend_d = 1'b0;
            sign_d     = d_in[WIDTH-1];
            mag_d      = mag_in;
            bcd_d      = '0;
            cnt_d      = CW'(WIDTH);
            state_d    = SHIFT;
          end
        end
      end

      SHIFT: begin
        bcd_d = shift_cat[BW+WIDTH-1:WIDTH];
        mag_d = shift_cat[WIDTH-1:0];
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
        end
      end

      DONE: begin
        if (!err_pend_q) begin
          bcd_out_d  = bcd_q;
          sign_out_d = sign_q;
          err_out_d  = 1'b0;
          ovr_d      = high_digits_nz;
        end
        err_pend_d = 1'b0;
        valid_d    = 1'b1;
        busy_d     = 1'b0;
        state_d    = IDLE;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      mag_q      <= '0;
      bcd_q      <= '0;
      sign_q     <= 1'b0;
      err_pend_q <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      bcd_out_q  <= '0;
      sign_out_q <= 1'b0;
      err_out_q  <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mag_q      <= mag_d;
      bcd_q      <= bcd_d;
      sign_q     <= sign_d;
      err_pend_q <= err_pend_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
      bcd_out_q  <= bcd_out_d;
      sign_out_q <= sign_out_d;
      err_out_q  <= err_out_d;
      ovr_q      <= ovr_d;
    end
  end

  assign busy        = busy_q;
  assign valid_out   = valid_q;
  assign bcd_out     = bcd_out_q;
  assign sign        = sign_out_q;
  assign err_out     = err_out_q;
  assign ovr_disp    = ovr_q;
  assign dbg_state_o = state_q;

endmodule
